// File: rtl/shared_div_if.sv
// Request/response bundle between NUM_REQ cores and the shared divider.
// Packed buses carry one WIDTH-bit (or 3-bit funct3) slice per requester.
interface shared_div_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_op1;
   logic [NUM_REQ*WIDTH-1:0] req_op2;
   logic [NUM_REQ*3-1:0]     req_funct3;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [NUM_REQ-1:0]       resp_ready;
   logic [WIDTH-1:0]         resp_data;
   logic                     busy;

   modport slave (
      input  req_valid, req_op1, req_op2, req_funct3, resp_ready,
      output req_ready, resp_valid, resp_data, busy
   );

   modport master (
      output req_valid, req_op1, req_op2, req_funct3, resp_ready,
      input  req_ready, resp_valid, resp_data, busy
   );
endinterface

// File: rtl/shared_div_arbiter.sv
// Round-robin shared radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//  state  | meaning
//  IDLE   | arbitrate; grant winner, latch operands
//  CALC   | one quotient bit per cycle, WIDTH cycles
//  DONE   | hold response to owner until resp_ready[owner]
module shared_div_arbiter #(
   parameter int WIDTH   = 32,
   parameter int NUM_REQ = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   shared_div_if.slave  bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    rr, owner, win;
   logic             win_found;
   int               arb_idx;
   logic [WIDTH-1:0] w_op1, w_op2, w_mag1, w_mag2, fast_val;
   logic [2:0]       w_f3;
   logic             w_signed, fast, accept, last;
   logic [WIDTH-1:0] q, d, result, q_nxt, fix_val;
   logic [WIDTH:0]   r, r_sh, r_nxt;
   logic             q_bit;
   logic [CW-1:0]    cnt;
   logic             rem_op, neg_q, neg_r;

   // Search starts just past the last owner so every requester gets a turn.
   always_comb begin
      win       = rr;
      win_found = 1'b0;
      arb_idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         arb_idx = int'(rr) + k;
         if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
         if (!win_found && bus.req_valid[arb_idx]) begin
            win_found = 1'b1;
            win       = IW'(arb_idx);
         end
      end
   end

   assign w_op1    = bus.req_op1[int'(win)*WIDTH +: WIDTH];
   assign w_op2    = bus.req_op2[int'(win)*WIDTH +: WIDTH];
   assign w_f3     = bus.req_funct3[int'(win)*3 +: 3];
   assign w_signed = ~w_f3[0];
   assign w_mag1   = (w_signed && w_op1[WIDTH-1]) ? -w_op1 : w_op1;
   assign w_mag2   = (w_signed && w_op2[WIDTH-1]) ? -w_op2 : w_op2;
   assign accept   = (state == S_IDLE) && win_found;
   assign last     = (cnt == CW'(WIDTH-1));

   // Results the RV32M spec defines without iterating.
   always_comb begin
      fast     = 1'b1;
      fast_val = '0;
      if (!w_f3[2])
         fast_val = '0;
      else if (w_op2 == '0)
         fast_val = w_f3[1] ? w_op1 : '1;
      else if (w_signed && (w_op1 == MIN_NEG) && (w_op2 == '1))
         fast_val = w_f3[1] ? '0 : w_op1;
      else
         fast = 1'b0;
   end

   always_comb begin
      r_sh    = {r[WIDTH-1:0], q[WIDTH-1]};
      q_bit   = (r_sh >= {1'b0, d});
      r_nxt   = q_bit ? (r_sh - {1'b0, d}) : r_sh;
      q_nxt   = {q[WIDTH-2:0], q_bit};
      fix_val = rem_op ? (neg_r ? -r_nxt[WIDTH-1:0] : r_nxt[WIDTH-1:0])
                       : (neg_q ? -q_nxt : q_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.resp_data  = '0;
      bus.busy       = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (win_found) begin
               bus.req_ready = NUM_REQ'(1) << win;
               state_nxt     = fast ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            bus.resp_valid = NUM_REQ'(1) << owner;
            bus.resp_data  = result;
            if (bus.resp_ready[owner]) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr     <= IW'(NUM_REQ-1);
         owner  <= '0;
         q      <= '0;
         d      <= '0;
         r      <= '0;
         cnt    <= '0;
         result <= '0;
         rem_op <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (accept) begin
         owner  <= win;
         rr     <= win;
         rem_op <= w_f3[1];
         neg_q  <= w_signed & (w_op1[WIDTH-1] ^ w_op2[WIDTH-1]);
         neg_r  <= w_signed & w_op1[WIDTH-1];
         q      <= w_mag1;
         d      <= w_mag2;
         r      <= '0;
         cnt    <= '0;
         if (fast) result <= fast_val;
      end else if (state == S_CALC) begin
         q   <= q_nxt;
         r   <= r_nxt;
         cnt <= cnt + CW'(1);
         if (last) result <= fix_val;
      end
   end
endmodule

// File: tb/tb_shared_div_arbiter.sv
// Directed bench for shared_div_arbiter: arithmetic, fast path, rotation,
// back-pressure and mid-operation reset.
module tb_shared_div_arbiter;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   shared_div_if #(.WIDTH(32), .NUM_REQ(4)) bus ();

   shared_div_arbiter #(.WIDTH(32), .NUM_REQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int who, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
      bus.req_funct3[who*3 +: 3] = f3;
      bus.req_op1[who*32 +: 32]  = a;
      bus.req_op2[who*32 +: 32]  = b;
      bus.req_valid[who]         = 1'b1;
   endtask

   // Called at the first negedge after the accepting edge.
   task automatic finish_op(input int who, input logic [31:0] exp, input int exp_lat,
                            input string tag);
      int lat;
      lat = 1;
      while (bus.resp_valid == '0 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_rvld"}, 32'(bus.resp_valid), 32'(1 << who));
      check({tag, "_data"}, bus.resp_data, exp);
      bus.resp_ready[who] = 1'b1;
      @(negedge clk);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check({tag, "_rclr"}, 32'(bus.resp_valid), 32'd0);
      bus.resp_ready[who] = 1'b0;
   endtask

   task automatic do_op(input int who, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input string tag);
      @(negedge clk);
      set_req(who, f3, a, b);
      #1;
      check({tag, "_rdy"}, 32'(bus.req_ready), 32'(1 << who));
      @(negedge clk);
      bus.req_valid[who] = 1'b0;
      finish_op(who, exp, exp_lat, tag);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.req_op1    = '0;
      bus.req_op2    = '0;
      bus.req_funct3 = '0;
      bus.resp_ready = '0;
      #2;
      check("rst_rdy",  32'(bus.req_ready), 32'd0);
      check("rst_rvld", 32'(bus.resp_valid), 32'd0);
      check("rst_data", bus.resp_data, 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Normal-path arithmetic
      do_op(0, 3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      do_op(0, 3'b111, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
      do_op(2, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      do_op(2, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      do_op(3, 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
      do_op(3, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
      do_op(1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
      do_op(1, 3'b111, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33, "remu_max_msb");

      // Fast path
      do_op(1, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
      do_op(1, 3'b111, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
      do_op(1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      do_op(1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
      do_op(1, 3'b000, 32'd9, 32'd3, 32'd0, 1, "f3_bad");

      // Continuous demand from all four rotates 0,1,2,3,0
      reset_pulse();
      for (int i = 0; i < 4; i++) set_req(i, 3'b111, 32'(10 + i), 32'd0);
      bus.resp_ready = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rot%0d_idle", k), 32'(bus.busy), 32'd0);
         check($sformatf("rot%0d_rdy", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
         @(negedge clk);
         check($sformatf("rot%0d_busy", k), 32'(bus.busy), 32'd1);
         check($sformatf("rot%0d_rvld", k), 32'(bus.resp_valid), 32'(1 << (k % 4)));
         check($sformatf("rot%0d_data", k), bus.resp_data, 32'(10 + (k % 4)));
         @(negedge clk);
      end
      bus.req_valid  = '0;
      bus.resp_ready = '0;

      // Back-pressure: response held, other requester and its resp_ready ignored
      @(negedge clk);
      set_req(1, 3'b100, 32'd20, 32'd3);
      #1;
      check("bp_rdy", 32'(bus.req_ready), 32'b0010);
      @(negedge clk);
      bus.req_valid[1] = 1'b0;
      begin
         int lat;
         lat = 1;
         while (bus.resp_valid == '0 && lat < 200) begin
            @(negedge clk);
            lat++;
         end
         check("bp_lat", 32'(lat), 32'd33);
      end
      set_req(2, 3'b101, 32'd8, 32'd2);
      bus.resp_ready[2] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d_rvld", c), 32'(bus.resp_valid), 32'b0010);
         check($sformatf("bp_hold%0d_data", c), bus.resp_data, 32'd6);
         check($sformatf("bp_hold%0d_rdy", c), 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready[1] = 1'b1;
      @(negedge clk);
      check("bp_rel_busy", 32'(bus.busy), 32'd0);
      check("bp_rel_rvld", 32'(bus.resp_valid), 32'd0);
      check("bp_rel_next", 32'(bus.req_ready), 32'b0100);
      bus.req_valid  = '0;
      bus.resp_ready = '0;

      // Reset mid-CALC aborts and restores the round-robin pointer
      @(negedge clk);
      set_req(0, 3'b100, 32'd1000, 32'd7);
      @(negedge clk);
      bus.req_valid[0] = 1'b0;
      repeat (14) @(negedge clk);
      check("abort_busy_pre", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_rvld", 32'(bus.resp_valid), 32'd0);
      check("abort_rdy",  32'(bus.req_ready), 32'd0);
      check("abort_data", bus.resp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_req(3, 3'b101, 32'd50, 32'd5);
      set_req(0, 3'b101, 32'd1000, 32'd10);
      #1;
      check("post_rst_rdy", 32'(bus.req_ready), 32'b0001);
      @(negedge clk);
      bus.req_valid = '0;
      finish_op(0, 32'd100, 33, "post_rst_op");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
